// File: rtl/thread_pc_sched.sv
// Per-thread program-counter bank with a barrel scheduler for the fetch stage.
// Holds one PC and one active bit per hardware thread, picks the fetch thread
// every advancing cycle, and applies branch redirects and start/halt commands.
// SKIP_IDLE=0 rotates through every slot, so inactive threads become bubbles;
// SKIP_IDLE=1 jumps straight to the next active thread.
module thread_pc_sched #(
   parameter int                     NUM_THREADS = 4,
   parameter int                     TID_W       = 2,
   parameter int                     ADDR_W      = 14,
   parameter int                     INCR        = 4,
   parameter logic [ADDR_W-1:0]      RESET_PC    = '0,
   parameter logic [NUM_THREADS-1:0] BOOT_MASK   = NUM_THREADS'(1),
   parameter bit                     SKIP_IDLE   = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   branch,
   input  logic [TID_W-1:0]       br_tid,
   input  logic [ADDR_W-1:0]      br_addr,
   input  logic                   start,
   input  logic [TID_W-1:0]       start_tid,
   input  logic [ADDR_W-1:0]      start_pc,
   input  logic                   halt,
   input  logic [TID_W-1:0]       halt_tid,
   output logic                   fetch_valid,
   output logic [TID_W-1:0]       fetch_tid,
   output logic [ADDR_W-1:0]      fetch_pc,
   input  logic [TID_W-1:0]       peek_tid,
   output logic [ADDR_W-1:0]      peek_pc,
   output logic [NUM_THREADS-1:0] active
);

   logic [ADDR_W-1:0] pc [NUM_THREADS];
   logic [TID_W-1:0]  cur_tid;
   logic [TID_W-1:0]  nxt_tid;
   logic [TID_W-1:0]  hi_tid;
   logic [TID_W-1:0]  lo_tid;
   logic              hi_found;
   logic              lo_found;

   assign fetch_tid = cur_tid;

   // Read muxes for the fetch slot and the peek port; a tid with no matching
   // thread falls through to the zero defaults.
   always_comb begin
      fetch_pc    = '0;
      fetch_valid = 1'b0;
      peek_pc     = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         if (cur_tid == TID_W'(t)) begin
            fetch_pc    = pc[t];
            fetch_valid = active[t];
         end
         if (peek_tid == TID_W'(t)) begin
            peek_pc = pc[t];
         end
      end
   end

   // Next fetch thread. In skip mode the first active thread above cur_tid
   // wins; otherwise wrap to the lowest active thread, which may be cur_tid
   // itself. With nothing active, cur_tid holds.
   always_comb begin
      nxt_tid  = cur_tid;
      hi_tid   = '0;
      lo_tid   = '0;
      hi_found = 1'b0;
      lo_found = 1'b0;
      if (SKIP_IDLE) begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            if (active[t] && !hi_found && (TID_W'(t) > cur_tid)) begin
               hi_tid   = TID_W'(t);
               hi_found = 1'b1;
            end
            if (active[t] && !lo_found) begin
               lo_tid   = TID_W'(t);
               lo_found = 1'b1;
            end
         end
         if (hi_found) begin
            nxt_tid = hi_tid;
         end else if (lo_found) begin
            nxt_tid = lo_tid;
         end
      end else begin
         if (cur_tid == TID_W'(NUM_THREADS - 1)) begin
            nxt_tid = '0;
         end else begin
            nxt_tid = cur_tid + TID_W'(1);
         end
      end
   end

   // Per-thread PC update: start load beats branch, branch beats increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            pc[t] <= RESET_PC;
         end
      end else begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            if (start && (start_tid == TID_W'(t))) begin
               pc[t] <= start_pc;
            end else if (en && branch && (br_tid == TID_W'(t))) begin
               pc[t] <= br_addr;
            end else if (en && fetch_valid && (cur_tid == TID_W'(t))) begin
               pc[t] <= pc[t] + ADDR_W'(INCR);
            end
         end
      end
   end

   // Active mask: start/halt act even while the pipeline is stalled; a start
   // and halt on the same thread leaves it running.
   always_ff @(posedge clk) begin
      if (rst) begin
         active <= BOOT_MASK;
      end else begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            if (start && (start_tid == TID_W'(t))) begin
               active[t] <= 1'b1;
            end else if (halt && (halt_tid == TID_W'(t))) begin
               active[t] <= 1'b0;
            end
         end
      end
   end

   // Scheduler slot register, frozen while the pipeline is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_tid <= '0;
      end else if (en) begin
         cur_tid <= nxt_tid;
      end
   end

endmodule

// File: tb/tb_thread_pc_sched.sv
// Bench for thread_pc_sched: a rotation instance and a skip-idle instance share
// all inputs. A behavioural model pushes the expected post-edge outputs of both
// instances into a scoreboard queue before each edge; they are popped and
// compared after the edge. Directed constant checks cover the test-plan cases.
module tb_thread_pc_sched;

   typedef struct packed {
      logic [1:0]  tid;
      logic [13:0] pc;
      logic        valid;
      logic [3:0]  act;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, en, branch, start, halt;
   logic [1:0]  br_tid, start_tid, halt_tid, peek_tid;
   logic [13:0] br_addr, start_pc;

   logic        d0_valid, s_valid;
   logic [1:0]  d0_tid, s_tid;
   logic [13:0] d0_pc, s_pc, d0_peek, s_peek;
   logic [3:0]  d0_act, s_act;

   int checks = 0;
   int failures = 0;

   exp_t        sb[$];
   logic [13:0] m_pc [2][4];
   logic [3:0]  m_act [2];
   int          m_cur [2];

   always #5 clk = ~clk;

   thread_pc_sched #(.NUM_THREADS(4), .TID_W(2), .ADDR_W(14), .INCR(4),
      .RESET_PC(14'h0), .BOOT_MASK(4'b1111), .SKIP_IDLE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .branch(branch), .br_tid(br_tid),
      .br_addr(br_addr), .start(start), .start_tid(start_tid),
      .start_pc(start_pc), .halt(halt), .halt_tid(halt_tid),
      .fetch_valid(d0_valid), .fetch_tid(d0_tid), .fetch_pc(d0_pc),
      .peek_tid(peek_tid), .peek_pc(d0_peek), .active(d0_act));

   thread_pc_sched #(.NUM_THREADS(4), .TID_W(2), .ADDR_W(14), .INCR(4),
      .RESET_PC(14'h0), .BOOT_MASK(4'b1111), .SKIP_IDLE(1'b1)) dut_s (
      .clk(clk), .rst(rst), .en(en), .branch(branch), .br_tid(br_tid),
      .br_addr(br_addr), .start(start), .start_tid(start_tid),
      .start_pc(start_pc), .halt(halt), .halt_tid(halt_tid),
      .fetch_valid(s_valid), .fetch_tid(s_tid), .fetch_pc(s_pc),
      .peek_tid(peek_tid), .peek_pc(s_peek), .active(s_act));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: later writes override earlier ones, giving start > branch > increment.
   task automatic model_step();
      logic [13:0] npc [4];
      logic [3:0]  nact;
      int          ncur;
      logic        found;
      exp_t        e;
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            for (int t = 0; t < 4; t++) npc[t] = 14'h0;
            nact = 4'b1111;
            ncur = 0;
         end else begin
            for (int t = 0; t < 4; t++) npc[t] = m_pc[m][t];
            if (en && m_act[m][m_cur[m]]) npc[m_cur[m]] = m_pc[m][m_cur[m]] + 14'd4;
            if (en && branch) npc[br_tid] = br_addr;
            if (start) npc[start_tid] = start_pc;
            nact = m_act[m];
            if (halt) nact[halt_tid] = 1'b0;
            if (start) nact[start_tid] = 1'b1;
            ncur = m_cur[m];
            if (en) begin
               if (m == 0) begin
                  ncur = (m_cur[m] + 1) % 4;
               end else begin
                  found = 1'b0;
                  for (int k = 1; k <= 4; k++) begin
                     if (!found && m_act[m][(m_cur[m] + k) % 4]) begin
                        ncur  = (m_cur[m] + k) % 4;
                        found = 1'b1;
                     end
                  end
               end
            end
         end
         for (int t = 0; t < 4; t++) m_pc[m][t] = npc[t];
         m_act[m] = nact;
         m_cur[m] = ncur;
         e.tid   = 2'(ncur);
         e.pc    = npc[ncur];
         e.valid = nact[ncur];
         e.act   = nact;
         sb.push_back(e);
      end
   endtask

   task automatic tick();
      exp_t e;
      model_step();
      @(posedge clk);
      #1;
      if (sb.size() < 2) begin
         chk("sb_underflow", 32'(sb.size()), 32'd2);
      end else begin
         e = sb.pop_front();
         chk("d0_tid", 32'(d0_tid), 32'(e.tid));
         chk("d0_pc", 32'(d0_pc), 32'(e.pc));
         chk("d0_valid", 32'(d0_valid), 32'(e.valid));
         chk("d0_active", 32'(d0_act), 32'(e.act));
         e = sb.pop_front();
         chk("s_tid", 32'(s_tid), 32'(e.tid));
         chk("s_pc", 32'(s_pc), 32'(e.pc));
         chk("s_valid", 32'(s_valid), 32'(e.valid));
         chk("s_active", 32'(s_act), 32'(e.act));
      end
   endtask

   task automatic peek_all();
      for (int t = 0; t < 4; t++) begin
         peek_tid = 2'(t);
         #1;
         chk("d0_peek", 32'(d0_peek), 32'(m_pc[0][t]));
         chk("s_peek", 32'(s_peek), 32'(m_pc[1][t]));
      end
   endtask

   logic [13:0] save0, save2, save_spc;
   int          save_cur;

   initial begin
      rst = 1'b1; en = 1'b0; branch = 1'b0; start = 1'b0; halt = 1'b0;
      br_tid = '0; start_tid = '0; halt_tid = '0; peek_tid = '0;
      br_addr = '0; start_pc = '0;
      for (int m = 0; m < 2; m++) begin
         m_act[m] = 4'b0; m_cur[m] = 0;
         for (int t = 0; t < 4; t++) m_pc[m][t] = 14'h0;
      end

      // Reset state
      tick(); tick();
      chk("rst_tid", 32'(d0_tid), 32'd0);
      chk("rst_pc", 32'(d0_pc), 32'd0);
      chk("rst_valid", 32'(d0_valid), 32'd1);
      chk("rst_active", 32'(d0_act), 32'hF);

      // Fixed rotation, all threads active
      rst = 1'b0; en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("rot_tid", 32'(d0_tid), 32'(i % 4));
         chk("rot_pc", 32'(d0_pc), 32'((i / 4) * 4));
         tick();
      end

      // Branch colliding with the increment of the fetching thread
      tick(); tick();
      chk("col_tid", 32'(d0_tid), 32'd2);
      chk("col_pc", 32'(d0_pc), 32'h8);
      branch = 1'b1; br_tid = 2'd2; br_addr = 14'h100;
      tick();
      branch = 1'b0;
      peek_tid = 2'd2; #1; chk("col_pk2", 32'(d0_peek), 32'h100);
      peek_tid = 2'd0; #1; chk("col_pk0", 32'(d0_peek), 32'hC);
      peek_tid = 2'd1; #1; chk("col_pk1", 32'(d0_peek), 32'hC);
      peek_tid = 2'd3; #1; chk("col_pk3", 32'(d0_peek), 32'h8);
      tick(); tick(); tick();
      chk("col_refetch_tid", 32'(d0_tid), 32'd2);
      chk("col_refetch_pc", 32'(d0_pc), 32'h100);

      // Stall with a branch pulsed: nothing moves, branch is lost
      en = 1'b0; branch = 1'b1; br_tid = 2'd0; br_addr = 14'h200;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_tid", 32'(d0_tid), 32'd2);
         chk("stall_pc", 32'(d0_pc), 32'h100);
      end
      branch = 1'b0;
      peek_tid = 2'd0; #1; chk("stall_br_lost", 32'(d0_peek), 32'h10);
      peek_all();

      // Mask 4'b1010: halt threads 0 and 2 while stalled
      halt = 1'b1; halt_tid = 2'd0; tick();
      halt_tid = 2'd2; tick();
      halt = 1'b0;
      chk("mask_active", 32'(s_act), 32'hA);
      save0 = m_pc[0][0]; save2 = m_pc[0][2];
      en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("skip_tid", 32'(s_tid), (k % 2 == 0) ? 32'd3 : 32'd1);
         chk("skip_valid", 32'(s_valid), 32'd1);
         chk("rot_bubble", 32'(d0_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      peek_tid = 2'd0; #1; chk("idle_pc0", 32'(d0_peek), 32'(save0));
      peek_tid = 2'd2; #1; chk("idle_pc2", 32'(d0_peek), 32'(save2));

      // Wrap: start thread 1 near the top of the address space
      en = 1'b0; start = 1'b1; start_tid = 2'd1; start_pc = 14'h3FFC;
      tick();
      start = 1'b0;
      peek_tid = 2'd1; #1; chk("wrap_start", 32'(d0_peek), 32'h3FFC);
      en = 1'b1;
      tick(); tick(); tick();
      chk("wrap_tid", 32'(d0_tid), 32'd1);
      chk("wrap_fetch_pc", 32'(d0_pc), 32'h3FFC);
      tick();
      peek_tid = 2'd1; #1; chk("wrap_pc", 32'(d0_peek), 32'h0);

      // Same-cycle halt and start on thread 0: start wins
      en = 1'b0; start = 1'b1; start_tid = 2'd0; start_pc = 14'h40;
      halt = 1'b1; halt_tid = 2'd0;
      tick();
      start = 1'b0; halt = 1'b0;
      chk("sh_active0", 32'(d0_act[0]), 32'd1);
      peek_tid = 2'd0; #1; chk("sh_pc0", 32'(d0_peek), 32'h40);
      peek_all();

      // Halt every thread; skip-mode scheduler must freeze with no valid slot
      halt = 1'b1;
      for (int t = 0; t < 4; t++) begin
         halt_tid = 2'(t);
         tick();
      end
      halt = 1'b0;
      chk("all_halted", 32'(s_act), 32'h0);
      save_cur = m_cur[1];
      save_spc = m_pc[1][save_cur];
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("halt_s_valid", 32'(s_valid), 32'd0);
         chk("halt_s_tid", 32'(s_tid), 32'(save_cur));
         chk("halt_s_pc", 32'(s_pc), 32'(save_spc));
         chk("halt_d0_valid", 32'(d0_valid), 32'd0);
      end

      // Reset mid-operation with commands pending
      rst = 1'b1; branch = 1'b1; br_tid = 2'd3; br_addr = 14'h123;
      start = 1'b1; start_tid = 2'd3; start_pc = 14'h77;
      tick();
      rst = 1'b0; branch = 1'b0; start = 1'b0; en = 1'b0;
      chk("rst2_tid", 32'(d0_tid), 32'd0);
      chk("rst2_pc", 32'(d0_pc), 32'd0);
      chk("rst2_active", 32'(s_act), 32'hF);
      peek_tid = 2'd3; #1; chk("rst2_pk3", 32'(d0_peek), 32'd0);
      peek_all();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
